// File: rtl/addsub_arbiter.sv
// Round-robin arbiter in front of a shared add/subtract unit.
// One operation in flight at a time: IDLE grants, EXEC computes, RESP holds the result until taken.
module addsub_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH:0]           rsp_data,
  output logic                          busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       grant;
  logic                  grant_any;
  logic [ID_W-1:0]       idx;
  logic                  op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Walk upward from the requester after last_grant, wrapping at NUM_REQ-1.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    idx       = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx == ID_W'(NUM_REQ - 1)) idx = '0;
      else                           idx = idx + 1'b1;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && grant_any) req_ready[grant] = 1'b1;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_id     <= '0;
      rsp_data   <= '0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_grant <= grant;
            rsp_id     <= grant;
            op_q       <= req_op[grant];
            a_q        <= a_arr[grant];
            b_q        <= b_arr[grant];
          end
        end
        EXEC: begin
          // Bit DATA_WIDTH is the carry for add and the borrow for sub.
          if (op_q) rsp_data <= {1'b0, a_q} - {1'b0, b_q};
          else      rsp_data <= {1'b0, a_q} + {1'b0, b_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter (W=8, N=3): directed vectors, expected grants and
// results queued by the driver, checked by an independent negedge monitor.
module tb_addsub_arbiter;
  localparam int W = 8;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W:0]     rsp_data;
  logic           busy;

  logic [10:0] exp_q[$];
  logic [1:0]  exp_g_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int grant_count = 0;
  int prev_cyc = 0;
  bit have_prev = 0;
  bit prev_valid = 0;
  bit chk_gap = 0;

  addsub_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[i]        = op;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise req_valid, wait for the grant edge, then drop it and scramble the operands.
  task automatic issue(input logic [N-1:0] mask);
    int n;
    n = 0;
    req_valid = mask;
    #1;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL issue_timeout: got no req_ready expected a grant for mask %b", mask);
    end
    tick();
    req_valid = '0;
    req_a = 24'($urandom);
    req_b = 24'($urandom);
    req_op = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_grants(input int target);
    int n;
    n = 0;
    while (grant_count < target && n < 100) begin
      tick();
      n++;
    end
    check("wait_grants", 32'(grant_count), 32'(target));
  endtask

  // Monitor: grant order, grant spacing, response latency and response contents.
  always @(negedge clk) begin
    if (rst) begin
      have_prev  = 0;
      prev_valid = 0;
    end else begin
      if (req_ready != '0) begin
        logic [1:0] gid;
        gid = '0;
        for (int k = 0; k < N; k++) if (req_ready[k]) gid = 2'(k);
        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        if (exp_g_q.size() == 0) check("grant_unexpected", 32'(gid), 32'hFFFF);
        else check("grant_id", 32'(gid), 32'(exp_g_q.pop_front()));
        if (have_prev && chk_gap) check("grant_gap", 32'(cyc - prev_cyc), 32'd3);
        prev_cyc  = cyc;
        have_prev = 1;
        grant_count++;
      end
      if (rsp_valid && !prev_valid) check("rsp_latency", 32'(cyc - prev_cyc), 32'd2);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'({rsp_id, rsp_data}), 32'hFFFF);
        else check("rsp_id_data", 32'({rsp_id, rsp_data}), 32'(exp_q.pop_front()));
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '1;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    tick();
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Directed single operations, each owned by the next requester in rotation.
    set_req(0, 1'b0, 8'd200, 8'd100); exp_g_q.push_back(2'd0); exp_q.push_back({2'd0, 9'h12C});
    issue(3'b001); wait_idle();
    set_req(1, 1'b1, 8'd5, 8'd7);     exp_g_q.push_back(2'd1); exp_q.push_back({2'd1, 9'h1FE});
    issue(3'b010); wait_idle();
    set_req(2, 1'b0, 8'd255, 8'd255); exp_g_q.push_back(2'd2); exp_q.push_back({2'd2, 9'h1FE});
    issue(3'b100); wait_idle();
    set_req(0, 1'b1, 8'd7, 8'd5);     exp_g_q.push_back(2'd0); exp_q.push_back({2'd0, 9'h002});
    issue(3'b001); wait_idle();
    set_req(1, 1'b1, 8'd0, 8'd255);   exp_g_q.push_back(2'd1); exp_q.push_back({2'd1, 9'h101});
    issue(3'b010); wait_idle();
    set_req(2, 1'b1, 8'd100, 8'd100); exp_g_q.push_back(2'd2); exp_q.push_back({2'd2, 9'h000});
    issue(3'b100); wait_idle();

    // Contention from reset release: all three requesters held valid.
    rst = 1'b1;
    req_valid = '1;
    set_req(0, 1'b0, 8'd200, 8'd100);
    set_req(1, 1'b1, 8'd5, 8'd7);
    set_req(2, 1'b0, 8'd10, 8'd20);
    tick();
    @(negedge clk);
    check("rst_req_ready_contention", 32'(req_ready), 32'd0);
    check("rst_busy_contention", 32'(busy), 32'd0);
    tick();
    grant_count = 0;
    chk_gap = 1;
    exp_g_q.push_back(2'd0); exp_q.push_back({2'd0, 9'h12C});
    exp_g_q.push_back(2'd1); exp_q.push_back({2'd1, 9'h1FE});
    exp_g_q.push_back(2'd2); exp_q.push_back({2'd2, 9'h01E});
    exp_g_q.push_back(2'd0); exp_q.push_back({2'd0, 9'h12C});
    rst = 1'b0;
    wait_grants(4);

    // Backpressure on the fourth result while everyone stays valid.
    chk_gap = 0;
    rsp_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'h12C);
      check("bp_rsp_id", 32'(rsp_id), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    tick();
    exp_g_q.push_back(2'd1); exp_q.push_back({2'd1, 9'h1FE});
    exp_g_q.push_back(2'd2);
    rsp_ready = 1'b1;
    tick();
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_req_ready", 32'(req_ready), 32'b010);

    // Reset pulse during EXEC of requester 2: its result must never appear.
    wait_grants(6);
    check("exec_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    exp_g_q.push_back(2'd0); exp_q.push_back({2'd0, 9'h12C});
    tick();
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_data", 32'(rsp_data), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'b001);
    wait_grants(7);
    req_valid = '0;
    wait_idle();
    tick();
    tick();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_g_q_drained", 32'(exp_g_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
